// File: rtl/tail_lamp_sequencer.sv
// Tail lamp sequencer: sequential turn patterns, hazard flash and brake
// override for LAMPS lamps per side, paced by a runtime-loadable prescaler.
// Lamp and busy outputs are decoded from the next state and step, and are
// registered at the same edge, so they have a one-cycle latency from inputs.
module tail_lamp_sequencer #(
  parameter int               LAMPS     = 3,
  parameter int               DIV_W     = 24,
  parameter logic [DIV_W-1:0] DIV_RESET = 24'd999999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             turn_left,
  input  logic             turn_right,
  input  logic             hazard,
  input  logic             brake,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic [LAMPS-1:0] left_lamp,
  output logic [LAMPS-1:0] right_lamp,
  output logic             busy
);

  // Step runs 0..LAMPS for turns (LAMPS+1 pattern phases), 0..1 for hazard.
  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(LAMPS);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

  state_t           state_reg, state_next, req;
  logic [SW-1:0]    step_reg, step_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic             tick;
  logic [LAMPS-1:0] therm;
  logic [LAMPS-1:0] left_next, right_next;
  logic             busy_next;

  // Request decode: both turns together are treated as a hazard request.
  always_comb begin
    req = IDLE;
    if (hazard || (turn_left && turn_right)) req = HAZ;
    else if (turn_left)                      req = LEFT;
    else if (turn_right)                     req = RIGHT;
  end

  assign tick = (cnt_reg == div_reg);

  // Next-state logic: divisor load beats a mode change, which beats a tick.
  always_comb begin
    state_next = req;
    step_next  = step_reg;
    cnt_next   = cnt_reg;
    div_next   = div_reg;
    if (div_load) begin
      div_next  = div_value;
      cnt_next  = '0;
      step_next = '0;
    end else if (req != state_reg) begin
      cnt_next  = '0;
      step_next = '0;
    end else begin
      cnt_next = tick ? '0 : cnt_reg + DIV_W'(1);
      if (tick) begin
        case (state_reg)
          LEFT, RIGHT: step_next = (step_reg == STEP_MAX) ? '0 : step_reg + SW'(1);
          HAZ:         step_next = step_reg ^ SW'(1);
          default:     step_next = '0;
        endcase
      end
    end
  end

  // Thermometer pattern, innermost lamp lights first.
  generate
    for (genvar gi = 0; gi < LAMPS; gi++) begin : g_therm
      assign therm[gi] = (step_next > SW'(gi));
    end
  endgenerate

  // Lamp decode from the next state so outputs land together with it.
  always_comb begin
    left_next  = brake ? '1 : '0;
    right_next = brake ? '1 : '0;
    case (state_next)
      LEFT:  left_next  = therm;
      RIGHT: right_next = therm;
      HAZ: begin
        left_next  = (step_next == SW'(1)) ? '1 : '0;
        right_next = (step_next == SW'(1)) ? '1 : '0;
      end
      default: ;
    endcase
    busy_next = (state_next != IDLE);
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      step_reg   <= '0;
      cnt_reg    <= '0;
      div_reg    <= DIV_RESET;
      left_lamp  <= '0;
      right_lamp <= '0;
      busy       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      cnt_reg    <= cnt_next;
      div_reg    <= div_next;
      left_lamp  <= left_next;
      right_lamp <= right_next;
      busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_tail_lamp_sequencer.sv
// Directed bench for tail_lamp_sequencer (LAMPS=3, short reset divisor).
// Each table row holds inputs for n cycles; outputs are checked after every
// one of those edges against the row's hand-computed expectation.
module tb_tail_lamp_sequencer;

  localparam int DW = 24;
  localparam logic [DW-1:0] DRST = 24'd5;  // reset tick period = 6 cycles

  logic          clk = 1'b0;
  logic          rst, turn_left, turn_right, hazard, brake, div_load;
  logic [DW-1:0] div_value;
  logic [2:0]    left_lamp, right_lamp;
  logic          busy;

  int checks = 0;
  int errors = 0;

  tail_lamp_sequencer #(.LAMPS(3), .DIV_W(DW), .DIV_RESET(DRST)) dut (
    .clk(clk), .rst(rst), .turn_left(turn_left), .turn_right(turn_right),
    .hazard(hazard), .brake(brake), .div_load(div_load), .div_value(div_value),
    .left_lamp(left_lamp), .right_lamp(right_lamp), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, tl, tr, hz, br, dl;
    logic [DW-1:0] dv;
    int            n;
    logic [2:0]    el, er;
    logic          eb;
    string         name;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, tl, tr, hz, br, dl, input int dv, input int n,
                     input logic [2:0] el, er, input logic eb, input string name);
    vec_t v;
    v.rst = r; v.tl = tl; v.tr = tr; v.hz = hz; v.br = br; v.dl = dl;
    v.dv = DW'(dv); v.n = n; v.el = el; v.er = er; v.eb = eb; v.name = name;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, tl, tr, hz, br, dl, input logic [DW-1:0] dv);
    rst = r; turn_left = tl; turn_right = tr; hazard = hz; brake = br;
    div_load = dl; div_value = dv;
  endtask

  task automatic check(input string name, input int idx, input logic [2:0] el, er,
                       input logic eb);
    checks++;
    if (left_lamp !== el || right_lamp !== er || busy !== eb) begin
      errors++;
      $display("FAIL %s[%0d]: got L=%b R=%b busy=%b, expected L=%b R=%b busy=%b",
               name, idx, left_lamp, right_lamp, busy, el, er, eb);
    end else begin
      $display("ok   %s[%0d]: L=%b R=%b busy=%b", name, idx, left_lamp, right_lamp, busy);
    end
  endtask

  initial begin
    int cyc;
    drive(1, 1, 1, 1, 1, 1, 3);

    //    rst tl tr hz br dl dv  n  left    right   busy
    // reset with every input high, then the reset divisor (period 6)
    add(1, 1, 1, 1, 1, 1, 3, 2, 3'b000, 3'b000, 0, "reset");
    add(0, 1, 0, 0, 0, 0, 0, 6, 3'b000, 3'b000, 1, "rstdiv_s0");
    add(0, 1, 0, 0, 0, 0, 0, 6, 3'b001, 3'b000, 1, "rstdiv_s1");
    add(0, 1, 0, 0, 0, 0, 0, 1, 3'b011, 3'b000, 1, "rstdiv_s2");
    // load div=3 during LEFT: pattern restarts, 4 cycles per step
    add(0, 1, 0, 0, 0, 1, 3, 1, 3'b000, 3'b000, 1, "left_load");
    add(0, 1, 0, 0, 0, 0, 0, 3, 3'b000, 3'b000, 1, "left_s0");
    add(0, 1, 0, 0, 0, 0, 0, 4, 3'b001, 3'b000, 1, "left_s1");
    add(0, 1, 0, 0, 0, 0, 0, 4, 3'b011, 3'b000, 1, "left_s2");
    add(0, 1, 0, 0, 0, 0, 0, 4, 3'b111, 3'b000, 1, "left_s3");
    add(0, 1, 0, 0, 0, 0, 0, 4, 3'b000, 3'b000, 1, "left_wrap");
    add(0, 1, 0, 0, 0, 0, 0, 1, 3'b001, 3'b000, 1, "left_s1b");
    // right turn with brake: left side solid, right pattern runs
    add(0, 0, 1, 0, 1, 0, 0, 4, 3'b111, 3'b000, 1, "rbrk_s0");
    add(0, 0, 1, 0, 1, 0, 0, 4, 3'b111, 3'b001, 1, "rbrk_s1");
    add(0, 0, 1, 0, 1, 0, 0, 4, 3'b111, 3'b011, 1, "rbrk_s2");
    add(0, 0, 1, 0, 0, 0, 0, 4, 3'b000, 3'b111, 1, "right_s3");
    add(0, 0, 1, 0, 0, 0, 0, 1, 3'b000, 3'b000, 1, "right_wrap");
    // left mid-pattern, then hazard with brake held
    add(0, 1, 0, 0, 0, 0, 0, 4, 3'b000, 3'b000, 1, "l2h_s0");
    add(0, 1, 0, 0, 0, 0, 0, 4, 3'b001, 3'b000, 1, "l2h_s1");
    add(0, 1, 0, 0, 0, 0, 0, 4, 3'b011, 3'b000, 1, "l2h_s2");
    add(0, 1, 0, 1, 1, 0, 0, 4, 3'b000, 3'b000, 1, "haz_off");
    add(0, 1, 0, 1, 1, 0, 0, 4, 3'b111, 3'b111, 1, "haz_on");
    add(0, 1, 0, 1, 1, 0, 0, 4, 3'b000, 3'b000, 1, "haz_off2");
    add(0, 1, 0, 1, 1, 0, 0, 1, 3'b111, 3'b111, 1, "haz_on2");
    // both turns behave as hazard (continues seamlessly), drop one -> restart
    add(0, 1, 1, 0, 0, 0, 0, 3, 3'b111, 3'b111, 1, "both_on");
    add(0, 1, 1, 0, 0, 0, 0, 4, 3'b000, 3'b000, 1, "both_off");
    add(0, 1, 1, 0, 0, 0, 0, 1, 3'b111, 3'b111, 1, "both_on2");
    add(0, 1, 0, 0, 0, 0, 0, 4, 3'b000, 3'b000, 1, "drop_s0");
    add(0, 1, 0, 0, 0, 0, 0, 4, 3'b001, 3'b000, 1, "drop_s1");
    add(0, 1, 0, 0, 0, 0, 0, 4, 3'b011, 3'b000, 1, "drop_s2");
    // reset mid-sequence restores IDLE and the reset divisor
    add(1, 1, 0, 0, 0, 0, 0, 1, 3'b000, 3'b000, 0, "mid_reset");
    add(0, 1, 0, 0, 0, 0, 0, 6, 3'b000, 3'b000, 1, "post_rst_s0");
    add(0, 1, 0, 0, 0, 0, 0, 1, 3'b001, 3'b000, 1, "post_rst_s1");
    // div=0: one step per cycle from 000
    add(0, 1, 0, 0, 0, 1, 0, 1, 3'b000, 3'b000, 1, "div0_load");
    add(0, 1, 0, 0, 0, 0, 0, 1, 3'b001, 3'b000, 1, "div0_s1");
    add(0, 1, 0, 0, 0, 0, 0, 1, 3'b011, 3'b000, 1, "div0_s2");
    add(0, 1, 0, 0, 0, 0, 0, 1, 3'b111, 3'b000, 1, "div0_s3");
    add(0, 1, 0, 0, 0, 0, 0, 1, 3'b000, 3'b000, 1, "div0_wrap");
    // idle with brake, then dropping everything
    add(0, 0, 0, 0, 1, 0, 0, 2, 3'b111, 3'b111, 0, "idle_brake");
    add(0, 0, 0, 0, 0, 0, 0, 2, 3'b000, 3'b000, 0, "idle_off");

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].tl, vq[i].tr, vq[i].hz, vq[i].br, vq[i].dl, vq[i].dv);
      for (int k = 0; k < vq[i].n; k++) begin
        @(posedge clk); #1;
        check(vq[i].name, k, vq[i].el, vq[i].er, vq[i].eb);
      end
    end

    // Hazard started together with a div=2 load: lamps must light after
    // exactly 3 further edges; bounded wait.
    drive(0, 0, 0, 1, 0, 1, 2);
    @(posedge clk); #1;
    check("hz_load", 0, 3'b000, 3'b000, 1);
    drive(0, 0, 0, 1, 0, 0, 0);
    cyc = 0;
    while (left_lamp !== 3'b111 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL hz_period: got %0d cycles to lamps on, expected 3", cyc);
    end else begin
      $display("ok   hz_period: %0d cycles", cyc);
    end
    check("hz_on", 0, 3'b111, 3'b111, 1);

    // Dropping a turn mid-pattern turns everything off on the next edge.
    drive(0, 1, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("drop_pre", 0, 3'b001, 3'b000, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("drop_idle", 0, 3'b000, 3'b000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
